// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl: ID-stage hazard detection, stall/flush, fwd select |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
   parameter int FWD_EN = 1,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_ra1,
   input  logic [REG_AW-1:0] id_ra2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_we,
   input  logic [REG_AW-1:0] id_wa,
   input  logic              id_load,
   input  logic              redirect,
   output logic              stall_if,
   output logic              stall_id,
   output logic              flush_id,
   output logic              bubble_ex,
   output logic              issue,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic              v;
      logic              we;
      logic [REG_AW-1:0] wa;
      logic              load;
   } sb_t;

   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   sb_t              r_ex, r_mem, r_wb;
   logic [1:0]       r_fwd_a, r_fwd_b;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   logic w_a_ex, w_a_mem, w_a_wb, w_b_ex, w_b_mem, w_b_wb;
   logic w_hazard, w_stall, w_issue, w_flush;
   logic [1:0] w_sel_a, w_sel_b;

   // x0 is hardwired zero, so a write to it never creates a dependency
   function automatic logic f_match(input sb_t s, input logic [REG_AW-1:0] ra,
                                    input logic use_rs);
      return s.v & s.we & (s.wa != '0) & (s.wa == ra) & use_rs;
   endfunction

   function automatic logic [1:0] f_sel(input logic m_ex, input logic m_mem,
                                        input logic m_wb);
      if (m_ex)       return 2'b01;
      else if (m_mem) return 2'b10;
      else if (m_wb)  return 2'b11;
      else            return 2'b00;
   endfunction

   always_comb begin
      w_a_ex  = f_match(r_ex,  id_ra1, id_use_rs1);
      w_a_mem = f_match(r_mem, id_ra1, id_use_rs1);
      w_a_wb  = f_match(r_wb,  id_ra1, id_use_rs1);
      w_b_ex  = f_match(r_ex,  id_ra2, id_use_rs2);
      w_b_mem = f_match(r_mem, id_ra2, id_use_rs2);
      w_b_wb  = f_match(r_wb,  id_ra2, id_use_rs2);

      w_hazard = 1'b0;
      w_sel_a  = 2'b00;
      w_sel_b  = 2'b00;
      if (FWD_EN != 0) begin
         w_hazard = id_valid & (w_a_ex | w_b_ex) & r_ex.load;
         w_sel_a  = f_sel(w_a_ex, w_a_mem, w_a_wb);
         w_sel_b  = f_sel(w_b_ex, w_b_mem, w_b_wb);
      end else begin
         w_hazard = id_valid & (w_a_ex | w_a_mem | w_a_wb | w_b_ex | w_b_mem | w_b_wb);
      end

      // a taken redirect discards the ID instruction, so it must not also stall
      w_stall = w_hazard & ~redirect;
      w_issue = id_valid & ~w_hazard & ~redirect & ~rst;
      w_flush = redirect & ~rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex        <= '0;
         r_mem       <= '0;
         r_wb        <= '0;
         r_fwd_a     <= 2'b00;
         r_fwd_b     <= 2'b00;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         if (w_issue) begin
            r_ex    <= '{v: 1'b1, we: id_we, wa: id_wa, load: id_load};
            r_fwd_a <= w_sel_a;
            r_fwd_b <= w_sel_b;
         end else begin
            r_ex    <= '0;
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
         end
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + c_cnt_one;
         if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + c_cnt_one;
      end
   end

   assign stall_if  = w_stall;
   assign stall_id  = w_stall;
   assign bubble_ex = w_stall;
   assign flush_id  = w_flush;
   assign issue     = w_issue;
   assign fwd_a     = r_fwd_a;
   assign fwd_b     = r_fwd_b;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: directed vector bench for pipeline_hazard_ctrl  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
   logic       id_we = 1'b0, id_load = 1'b0, redirect = 1'b0;
   logic [4:0] id_ra1 = '0, id_ra2 = '0, id_wa = '0;

   // f1_*: forwarding instance; f0_*: no-forwarding instance with 2-bit counters
   logic       f1_sif, f1_sid, f1_fl, f1_bub, f1_iss;
   logic [1:0] f1_fa, f1_fb;
   logic [31:0] f1_sc, f1_fc;
   logic       f0_sif, f0_sid, f0_fl, f0_bub, f0_iss;
   logic [1:0] f0_fa, f0_fb;
   logic [1:0] f0_sc, f0_fc;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.FWD_EN(1), .REG_AW(5), .CNT_W(32)) u_fwd (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_we(id_we), .id_wa(id_wa),
      .id_load(id_load), .redirect(redirect), .stall_if(f1_sif), .stall_id(f1_sid),
      .flush_id(f1_fl), .bubble_ex(f1_bub), .issue(f1_iss), .fwd_a(f1_fa), .fwd_b(f1_fb),
      .stall_cnt(f1_sc), .flush_cnt(f1_fc));

   pipeline_hazard_ctrl #(.FWD_EN(0), .REG_AW(5), .CNT_W(2)) u_nofwd (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_we(id_we), .id_wa(id_wa),
      .id_load(id_load), .redirect(redirect), .stall_if(f0_sif), .stall_id(f0_sid),
      .flush_id(f0_fl), .bubble_ex(f0_bub), .issue(f0_iss), .fwd_a(f0_fa), .fwd_b(f0_fb),
      .stall_cnt(f0_sc), .flush_cnt(f0_fc));

   typedef struct {
      logic       v;
      logic [4:0] ra1, ra2;
      logic       u1, u2, we;
      logic [4:0] wa;
      logic       ld, rd;
      logic       e_stall, e_flush, e_issue;
      logic [1:0] e_fa, e_fb;
   } vec_t;

   vec_t tv[19];

   function automatic vec_t mk(input logic v, input int ra1, input int ra2,
                               input logic u1, input logic u2, input logic we,
                               input int wa, input logic ld, input logic rd,
                               input logic es, input logic ef, input logic ei,
                               input logic [1:0] fa, input logic [1:0] fb);
      vec_t t;
      t.v = v; t.ra1 = 5'(ra1); t.ra2 = 5'(ra2); t.u1 = u1; t.u2 = u2; t.we = we;
      t.wa = 5'(wa); t.ld = ld; t.rd = rd; t.e_stall = es; t.e_flush = ef;
      t.e_issue = ei; t.e_fa = fa; t.e_fb = fb;
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input int ra1, input int ra2, input logic u1,
                        input logic u2, input logic we, input int wa, input logic ld,
                        input logic rd);
      @(negedge clk);
      id_valid = v; id_ra1 = 5'(ra1); id_ra2 = 5'(ra2); id_use_rs1 = u1;
      id_use_rs2 = u2; id_we = we; id_wa = 5'(wa); id_load = ld; redirect = rd;
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      id_valid = 1'b0; redirect = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // forwarding instance: EX fwd, load-use, WB fwd, x0, redirect over load-use
      tv[0]  = mk(1, 1, 2, 1, 1, 1, 5, 0, 0,  0, 0, 1, 2'b00, 2'b00); // add x5,x1,x2
      tv[1]  = mk(1, 5, 3, 1, 1, 1, 6, 0, 0,  0, 0, 1, 2'b00, 2'b00); // add x6,x5,x3
      tv[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b01, 2'b00);
      tv[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
      tv[4]  = mk(1, 1, 0, 1, 0, 1, 5, 1, 0,  0, 0, 1, 2'b00, 2'b00); // lw x5,0(x1)
      tv[5]  = mk(1, 5, 5, 1, 1, 1, 6, 0, 0,  1, 0, 0, 2'b00, 2'b00); // add x6,x5,x5
      tv[6]  = mk(1, 5, 5, 1, 1, 1, 6, 0, 0,  0, 0, 1, 2'b00, 2'b00);
      tv[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b10, 2'b10);
      tv[8]  = mk(1, 1, 2, 1, 1, 1, 7, 0, 0,  0, 0, 1, 2'b00, 2'b00); // add x7
      tv[9]  = mk(1, 1, 2, 1, 1, 1, 8, 0, 0,  0, 0, 1, 2'b00, 2'b00);
      tv[10] = mk(1, 1, 2, 1, 1, 1, 9, 0, 0,  0, 0, 1, 2'b00, 2'b00);
      tv[11] = mk(1, 7, 0, 1, 1, 1, 10, 0, 0, 0, 0, 1, 2'b00, 2'b00); // add x10,x7,x0
      tv[12] = mk(1, 1, 2, 1, 1, 1, 0, 0, 0,  0, 0, 1, 2'b11, 2'b00); // add x0,x1,x2
      tv[13] = mk(1, 0, 0, 1, 1, 1, 11, 0, 0, 0, 0, 1, 2'b00, 2'b00); // add x11,x0,x0
      tv[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
      tv[15] = mk(1, 1, 0, 1, 0, 1, 5, 1, 0,  0, 0, 1, 2'b00, 2'b00); // lw x5
      tv[16] = mk(1, 5, 5, 1, 1, 1, 6, 0, 1,  0, 1, 0, 2'b00, 2'b00); // redirect
      tv[17] = mk(1, 5, 5, 1, 1, 1, 6, 0, 0,  0, 0, 1, 2'b00, 2'b00); // EX was bubbled
      tv[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b10, 2'b10);

      do_reset();
      #2;
      chk("rst_stall", int'(f1_sid), 0);
      chk("rst_fwd_a", int'(f1_fa), 0);
      chk("rst_fwd_b", int'(f1_fb), 0);
      chk("rst_stall_cnt", int'(f1_sc), 0);
      chk("rst_flush_cnt", int'(f1_fc), 0);

      for (int i = 0; i < 19; i++) begin
         drive(tv[i].v, int'(tv[i].ra1), int'(tv[i].ra2), tv[i].u1, tv[i].u2,
               tv[i].we, int'(tv[i].wa), tv[i].ld, tv[i].rd);
         chk($sformatf("v%0d_stall_if", i),  int'(f1_sif), int'(tv[i].e_stall));
         chk($sformatf("v%0d_stall_id", i),  int'(f1_sid), int'(tv[i].e_stall));
         chk($sformatf("v%0d_bubble_ex", i), int'(f1_bub), int'(tv[i].e_stall));
         chk($sformatf("v%0d_flush_id", i),  int'(f1_fl),  int'(tv[i].e_flush));
         chk($sformatf("v%0d_issue", i),     int'(f1_iss), int'(tv[i].e_issue));
         chk($sformatf("v%0d_fwd_a", i),     int'(f1_fa),  int'(tv[i].e_fa));
         chk($sformatf("v%0d_fwd_b", i),     int'(f1_fb),  int'(tv[i].e_fb));
      end
      chk("fwd_stall_cnt", int'(f1_sc), 1);
      chk("fwd_flush_cnt", int'(f1_fc), 1);

      // no forwarding: dependent add waits for EX, MEM and WB to drain
      do_reset();
      drive(1, 1, 2, 1, 1, 1, 5, 0, 0);
      chk("nf_prod_issue", int'(f0_iss), 1);
      for (int c = 0; c < 3; c++) begin
         drive(1, 5, 3, 1, 1, 1, 6, 0, 0);
         chk($sformatf("nf_stall%0d", c), int'(f0_sid), 1);
         chk($sformatf("nf_noissue%0d", c), int'(f0_iss), 0);
      end
      drive(1, 5, 3, 1, 1, 1, 6, 0, 0);
      chk("nf_stall_end", int'(f0_sid), 0);
      chk("nf_issue", int'(f0_iss), 1);
      idle();
      chk("nf_fwd_a", int'(f0_fa), 0);
      chk("nf_fwd_b", int'(f0_fb), 0);
      chk("nf_stall_cnt", int'(f0_sc), 3);
      // a second dependent pair must leave the 2-bit counter pinned at all-ones
      drive(1, 1, 2, 1, 1, 1, 9, 0, 0);
      drive(1, 9, 9, 1, 1, 1, 4, 0, 0);
      chk("nf_stall_again", int'(f0_sid), 1);
      idle();
      chk("nf_stall_cnt_sat", int'(f0_sc), 3);
      for (int c = 0; c < 5; c++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      chk("nf_flush_cnt_sat", int'(f0_fc), 3);

      // reset during a load-use stall
      do_reset();
      drive(1, 1, 0, 1, 0, 1, 5, 1, 0);
      drive(1, 5, 5, 1, 1, 1, 6, 0, 0);
      chk("rs_stall_pre", int'(f1_sid), 1);
      @(negedge clk);
      rst = 1'b1;
      redirect = 1'b1;
      #2;
      chk("rs_issue_in_rst", int'(f1_iss), 0);
      chk("rs_flush_in_rst", int'(f1_fl), 0);
      @(negedge clk);
      rst = 1'b0;
      redirect = 1'b0;
      #2;
      chk("rs_stall_post", int'(f1_sid), 0);
      chk("rs_issue_post", int'(f1_iss), 1);
      chk("rs_fwd_a", int'(f1_fa), 0);
      chk("rs_stall_cnt", int'(f1_sc), 0);
      chk("rs_flush_cnt", int'(f1_fc), 0);
      drive(1, 6, 6, 1, 1, 1, 7, 0, 0);
      chk("rs_dep_nostall", int'(f1_sid), 0);
      idle();
      chk("rs_dep_fwd_a", int'(f1_fa), 1);
      chk("rs_dep_fwd_b", int'(f1_fb), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage RV32I pipeline.
- Tracks the destination register of every in-flight instruction in EX, MEM and WB with a small internal scoreboard shift register.
- Compares these against the sources of the instruction currently in ID. From that it generates IF/ID stall, ID/EX bubble, IF/ID flush on redirect, and the registered operand-forwarding selects consumed by EX.
- Sits beside the ID stage; drives the pipeline-register enables and the EX operand muxes.

Parameters:
- FWD_EN, 1: 1 = forwarding enabled (only load-use stalls); 0 = no forwarding, stall until producer has retired.
- REG_AW, 5: register address width.
- CNT_W, 32: width of the stall and flush performance counters.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_ra1  in  REG_AW  rs1 address of ID instruction.
- id_ra2  in  REG_AW  rs2 address of ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_we  in  1  ID instruction writes rd.
- id_wa  in  REG_AW  rd address of ID instruction.
- id_load  in  1  ID instruction is a load.
- redirect  in  1  EX resolved a taken branch/jump this cycle.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- flush_id  out  1  clear IF/ID to NOP.
- bubble_ex  out  1  load NOP into ID/EX.
- issue  out  1  ID instruction advances to EX this cycle.
- fwd_a  out  2  EX rs1 source: 00 regfile, 01 MEM result, 10 WB result, 11 retired-value hold register.
- fwd_b  out  2  same encoding, for rs2.
- stall_cnt  out  CNT_W  cycles with stall_id=1, saturating.
- flush_cnt  out  CNT_W  cycles with flush_id=1, saturating.

Behaviour:
- Scoreboard: three entries, EX, MEM and WB. Each holds {v, we, wa, load}.
- Scoreboard advance, every cycle: WB<=MEM; MEM<=EX; EX<=issue ? {1, id_we, id_wa, id_load} : all-zero bubble. There is no downstream back-pressure.
- Match rule: match(S, ra) = S.v & S.we & (S.wa != 0) & (S.wa == ra) & use_rs.
  - Register x0 never causes a hazard or a forward.
- Hazard when FWD_EN=1: hazard = id_valid & (match(EX, ra1) | match(EX, ra2)) & EX.load. This is the load-use case: exactly one stall cycle.
- Hazard when FWD_EN=0: hazard = id_valid & any match against EX, MEM or WB. Up to 3 stall cycles.
- Combinational outputs:
  - stall_if = stall_id = bubble_ex = hazard & ~redirect.
  - flush_id = redirect.
  - issue = id_valid & ~hazard & ~redirect.
- Redirect priority: redirect overrides hazard.
  - No stall is asserted.
  - EX captures a bubble.
  - IF/ID is flushed.
- Forwarding selects are registered, so they are valid while the consumer is in EX. They are loaded on the edge where issue=1, otherwise loaded with 00.
  - Per source, priority order: match(EX) -> 01, else match(MEM) -> 10, else match(WB) -> 11, else 00.
  - When FWD_EN=0, the selects are always 00.
- Load-use resolution: after the single stall cycle the load is in MEM at ID time. The consumer therefore issues with select 10 (WB result).
- Counters: increment by 1 per qualifying cycle and hold at all-ones.
- Reset (rst=1 at an edge): all scoreboard entries invalid; fwd_a = fwd_b = 00; both counters 0.
  - Because the scoreboard is empty, stall outputs are 0 in the cycle after reset.
  - While rst is high, issue and flush are forced to 0.
  - Reset mid-stall abandons the stall.

Test Plan:
- FWD_EN=1: add x5,x1,x2 then add x6,x5,x3 back-to-back -> no stall; fwd_a=01 in the consumer's EX cycle; stall_cnt=0.
- FWD_EN=1: lw x5,0(x1) then add x6,x5,x5 -> exactly 1 cycle with stall_if=stall_id=bubble_ex=1; then issue=1; fwd_a=fwd_b=10; stall_cnt=1.
- FWD_EN=1: producer x7, two independent instructions, then consumer of x7 -> fwd_a=11 (WB match at ID time); producer writing x0 then consumer of x0 -> fwd 00, no stall.
- Redirect=1 in the same cycle as a load-use hazard -> flush_id=1, stall_id=0, issue=0; EX entry becomes a bubble next cycle; flush_cnt=1.
- FWD_EN=0: add x5 then dependent add x6,x5 -> 3 consecutive stall cycles; issue on the 4th; fwd 00; stall_cnt=3.
- rst asserted during the load-use stall cycle -> next cycle stall_id=0, fwd 00, stall_cnt=0, flush_cnt=0; scoreboard empty, verified by no stall on a following dependent pair.
